// File: rtl/vote_pkg.sv
// Shared types and constants for the voting-machine front end.
// Holds the FSM state encoding, the candidate width and a one-hot-to-index helper.
package vote_pkg;

  localparam int CAND_W   = 2;
  localparam int NUM_CAND = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_QUALIFY  = 3'd1,
    ST_GRANT    = 3'd2,
    ST_WAIT_REL = 3'd3,
    ST_RESULT   = 3'd4
  } state_e;

  function automatic logic [CAND_W-1:0] onehot_idx(input logic [NUM_CAND-1:0] v);
    logic [CAND_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (v[i]) idx = CAND_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vote_press_arbiter_if.sv
// Button/mode inputs and vote/display outputs of the arbiter, bundled as one port.
// Pulses (vote_valid, disp_valid, reject) are single-cycle strobes; no back-pressure exists.
interface vote_press_arbiter_if import vote_pkg::*; #(
  parameter int BAL_W = 8
) ();
  logic              mode;
  logic              button1;
  logic              button2;
  logic              button3;
  logic              button4;
  logic              vote_valid;
  logic [CAND_W-1:0] vote_idx;
  logic              disp_valid;
  logic [CAND_W-1:0] disp_idx;
  logic              reject;
  logic              locked;
  logic [BAL_W-1:0]  ballots_cast;
  state_e            state_dbg;

  modport master (
    output mode, button1, button2, button3, button4,
    input  vote_valid, vote_idx, disp_valid, disp_idx, reject, locked, ballots_cast, state_dbg
  );

  modport slave (
    input  mode, button1, button2, button3, button4,
    output vote_valid, vote_idx, disp_valid, disp_idx, reject, locked, ballots_cast, state_dbg
  );
endinterface

// File: rtl/press_qualifier.sv
// Two-flop button synchroniser, one-hot detection and the shared hold counter.
// Counter: clr alone -> 0, en alone -> +1, clr with en -> 1 (start of a new hold).
module press_qualifier import vote_pkg::*; #(
  parameter int HOLD_CYCLES = 8,
  parameter int HC_W        = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_CAND-1:0] btn_raw,
  input  logic                hold_clr,
  input  logic                hold_en,
  output logic [NUM_CAND-1:0] btn_vec,
  output logic                onehot,
  output logic                any,
  output logic [HC_W-1:0]     hold_cnt
);

  logic [NUM_CAND-1:0] sync1_q, sync1_d;
  logic [NUM_CAND-1:0] sync2_q, sync2_d;
  logic [HC_W-1:0]     hold_cnt_q, hold_cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    if (hold_clr) begin
      hold_cnt_d = hold_en ? HC_W'(1) : '0;
    end else if (hold_en) begin
      hold_cnt_d = hold_cnt_q + HC_W'(1);
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      hold_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign btn_vec  = sync2_q;
  assign any      = |sync2_q;
  assign onehot   = any && ((sync2_q & (sync2_q - NUM_CAND'(1))) == '0);
  assign hold_cnt = hold_cnt_q;

endmodule

// File: rtl/vote_press_arbiter.sv
// Voting front end: qualifies single presses into one vote each, rejects multi-button
// presses and glitches, and in result mode turns a qualified press into a display select.
module vote_press_arbiter import vote_pkg::*; #(
  parameter int HOLD_CYCLES = 8,
  parameter int MAX_BALLOTS = 255,
  parameter int BAL_W       = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  vote_press_arbiter_if.slave   bus
);

  localparam int                HC_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [BAL_W-1:0]  MAX_B     = BAL_W'(MAX_BALLOTS);

  logic [NUM_CAND-1:0] btn_vec;
  logic                onehot, any;
  logic [HC_W-1:0]     hold_cnt;
  logic                hold_clr, hold_en;

  state_e              state_q, state_d;
  logic [CAND_W-1:0]   cand_q, cand_d;
  logic [CAND_W-1:0]   disp_idx_q, disp_idx_d;
  logic                disp_valid_q, disp_valid_d;
  logic                reject_q, reject_d;
  logic                res_done_q, res_done_d;
  logic                locked_q, locked_d;
  logic [BAL_W-1:0]    ballots_q, ballots_d;
  logic                vote_valid;
  logic                cand_match;

  press_qualifier #(.HOLD_CYCLES(HOLD_CYCLES), .HC_W(HC_W)) u_qual (
    .clock    (clock),
    .reset_n  (reset_n),
    .btn_raw  ({bus.button4, bus.button3, bus.button2, bus.button1}),
    .hold_clr (hold_clr),
    .hold_en  (hold_en),
    .btn_vec  (btn_vec),
    .onehot   (onehot),
    .any      (any),
    .hold_cnt (hold_cnt)
  );

  assign cand_match = (btn_vec == (NUM_CAND'(1) << cand_q));

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    disp_idx_d   = disp_idx_q;
    disp_valid_d = 1'b0;
    reject_d     = 1'b0;
    res_done_d   = res_done_q;
    locked_d     = locked_q;
    ballots_d    = ballots_q;
    hold_clr     = 1'b0;
    hold_en      = 1'b0;
    vote_valid   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        hold_clr = 1'b1;
        if (bus.mode) begin
          state_d    = ST_RESULT;
          res_done_d = 1'b0;
        end else if (any && locked_q) begin
          state_d = ST_WAIT_REL;
        end else if (onehot) begin
          state_d = ST_QUALIFY;
          cand_d  = onehot_idx(btn_vec);
          hold_en = 1'b1;
        end else if (any) begin
          reject_d = 1'b1;
          state_d  = ST_WAIT_REL;
        end
      end
      ST_QUALIFY: begin
        if (bus.mode) begin
          hold_clr   = 1'b1;
          state_d    = ST_RESULT;
          res_done_d = 1'b0;
        end else if (cand_match) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_clr = 1'b1;
            state_d  = ST_GRANT;
          end else begin
            hold_en = 1'b1;
          end
        end else begin
          // Early release is a glitch; any other pattern must be released first.
          hold_clr = 1'b1;
          reject_d = 1'b1;
          state_d  = any ? ST_WAIT_REL : ST_IDLE;
        end
      end
      ST_GRANT: begin
        vote_valid = 1'b1;
        if (ballots_q != MAX_B) begin
          ballots_d = ballots_q + BAL_W'(1);
          if (ballots_q + BAL_W'(1) == MAX_B) locked_d = 1'b1;
        end
        state_d = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        hold_clr = 1'b1;
        if (!any) begin
          state_d    = bus.mode ? ST_RESULT : ST_IDLE;
          res_done_d = 1'b0;
        end
      end
      ST_RESULT: begin
        if (!bus.mode) begin
          hold_clr = 1'b1;
          state_d  = any ? ST_WAIT_REL : ST_IDLE;
        end else if (res_done_q) begin
          hold_clr = 1'b1;
          if (!any) res_done_d = 1'b0;
        end else if (onehot) begin
          if (hold_cnt != '0 && cand_match) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_clr     = 1'b1;
              disp_valid_d = 1'b1;
              disp_idx_d   = cand_q;
              res_done_d   = 1'b1;
            end else begin
              hold_en = 1'b1;
            end
          end else begin
            cand_d   = onehot_idx(btn_vec);
            hold_clr = 1'b1;
            hold_en  = 1'b1;
          end
        end else begin
          hold_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cand_q       <= '0;
      disp_idx_q   <= '0;
      disp_valid_q <= 1'b0;
      reject_q     <= 1'b0;
      res_done_q   <= 1'b0;
      locked_q     <= 1'b0;
      ballots_q    <= '0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      disp_idx_q   <= disp_idx_d;
      disp_valid_q <= disp_valid_d;
      reject_q     <= reject_d;
      res_done_q   <= res_done_d;
      locked_q     <= locked_d;
      ballots_q    <= ballots_d;
    end
  end

  assign bus.vote_valid   = vote_valid;
  assign bus.vote_idx     = cand_q;
  assign bus.disp_valid   = disp_valid_q;
  assign bus.disp_idx     = disp_idx_q;
  assign bus.reject       = reject_q;
  assign bus.locked       = locked_q;
  assign bus.ballots_cast = ballots_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_vote_press_arbiter.sv
// Directed and randomized press scenarios for vote_press_arbiter, each scored against a
// press-level model: vote time/index, reject and display counts, ballot total and lock.
module tb_vote_press_arbiter;

  localparam int H    = 8;
  localparam int MAXB = 3;
  localparam int BW   = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  vote_press_arbiter_if #(.BAL_W(BW)) bus ();

  vote_press_arbiter #(.HOLD_CYCLES(H), .MAX_BALLOTS(MAXB), .BAL_W(BW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Observations, sampled on the falling edge.
  logic [17:0] exp_q[$];
  logic [17:0] act_q[$];
  int   act_rej  = 0;
  int   act_disp = 0;
  logic overlap  = 1'b0;

  always @(negedge clock) begin
    if (bus.vote_valid) act_q.push_back({cyc[15:0], bus.vote_idx});
    if (bus.reject) act_rej++;
    if (bus.disp_valid) act_disp++;
    if (bus.vote_valid && bus.disp_valid) overlap = 1'b1;
  end

  // Model state
  int         votes_m  = 0;
  int         exp_rej  = 0;
  int         exp_disp = 0;
  int         base_rej = 0;
  int         base_disp = 0;
  logic [1:0] exp_disp_idx = 2'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_buttons(input logic [3:0] m);
    bus.button1 = m[0];
    bus.button2 = m[1];
    bus.button3 = m[2];
    bus.button4 = m[3];
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    set_buttons(4'b0000);
    bus.mode = 1'b0;
    cycles(n);
    reset_n = 1'b1;
    cycles(2);
    votes_m = 0;
  endtask

  task automatic begin_scn();
    base_rej  = act_rej;
    base_disp = act_disp;
    exp_rej   = 0;
    exp_disp  = 0;
    act_q.delete();
    exp_q.delete();
  endtask

  // Press-level rules: what one isolated press from an idle machine must produce.
  task automatic model_press(input logic [3:0] mask, input int dur, input int start);
    int         n;
    logic [1:0] idx;
    int         vcyc;
    n = $countones(mask);
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (mask[i]) idx = 2'(i);
    if (bus.mode) begin
      if (n == 1 && dur >= H) begin
        exp_disp++;
        exp_disp_idx = idx;
      end
    end else if (votes_m >= MAXB) begin
      // locked: silently waits for release
    end else if (n > 1 || dur < H) begin
      exp_rej++;
    end else begin
      vcyc = start + H + 2;
      exp_q.push_back({vcyc[15:0], idx});
      votes_m++;
    end
  endtask

  task automatic press(input logic [3:0] mask, input int dur);
    model_press(mask, dur, cyc);
    set_buttons(mask);
    cycles(dur);
    set_buttons(4'b0000);
    cycles(8);
  endtask

  task automatic check_scn(input string tag);
    logic [17:0] a, e;
    #1;
    check({tag, " vote count"}, act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      check({tag, " vote cyc/idx"}, a, e);
    end
    check({tag, " reject count"}, act_rej - base_rej, exp_rej);
    check({tag, " disp count"}, act_disp - base_disp, exp_disp);
    if (exp_disp > 0) check({tag, " disp_idx"}, bus.disp_idx, exp_disp_idx);
    check({tag, " ballots_cast"}, bus.ballots_cast, votes_m);
    check({tag, " locked"}, bus.locked, (votes_m >= MAXB) ? 1 : 0);
    check({tag, " vote/disp overlap"}, overlap, 0);
  endtask

  initial begin
    logic [3:0] m;
    int         d;
    bus.mode = 1'b0;
    set_buttons(4'b0000);

    // T1: reset held, then released
    reset_n = 1'b0;
    cycles(10);
    check("t1 rst vote_valid", bus.vote_valid, 0);
    check("t1 rst reject", bus.reject, 0);
    check("t1 rst disp_valid", bus.disp_valid, 0);
    check("t1 rst disp_idx", bus.disp_idx, 0);
    check("t1 rst locked", bus.locked, 0);
    check("t1 rst ballots", bus.ballots_cast, 0);
    reset_n = 1'b1;
    cycles(3);
    votes_m = 0;
    check("t1 idle vote_valid", bus.vote_valid, 0);
    check("t1 idle ballots", bus.ballots_cast, 0);

    // T2: long single press, exactly one vote
    begin_scn();
    press(4'b0001, 20);
    check_scn("t2");

    // T3: one-cycle glitch
    begin_scn();
    press(4'b0001, 1);
    check_scn("t3");

    // T4: two buttons together, then a clean vote after release
    begin_scn();
    press(4'b0110, 20);
    press(4'b1000, 10);
    check_scn("t4");

    // T5a: result mode display select
    bus.mode = 1'b1;
    cycles(4);
    begin_scn();
    press(4'b0010, 20);
    check_scn("t5 result");
    bus.mode = 1'b0;
    cycles(4);

    // T5b: mode raised part-way through qualification
    begin_scn();
    set_buttons(4'b0001);
    cycles(5);
    bus.mode = 1'b1;
    cycles(3);
    set_buttons(4'b0000);
    cycles(8);
    bus.mode = 1'b0;
    cycles(8);
    check_scn("t5 mid-qualify");

    // Reset during qualification: no vote, counts cleared
    begin_scn();
    set_buttons(4'b0100);
    cycles(6);
    do_reset(3);
    cycles(8);
    check_scn("reset mid-qualify");

    // Randomized presses, isolated from one another
    for (int k = 0; k < 14; k++) begin
      begin_scn();
      if ($urandom_range(0, 3) == 3) begin
        m = 4'(($urandom_range(1, 3) << $urandom_range(0, 2)) | (4'b0001 << $urandom_range(0, 3)));
        if ($countones(m) < 2) m = 4'b1001;
      end else begin
        m = 4'b0001 << $urandom_range(0, 3);
      end
      d = $urandom_range(1, 16);
      press(m, d);
      check_scn("random");
    end

    // T6: lock after MAX_BALLOTS votes
    do_reset(4);
    begin_scn();
    for (int k = 0; k < 4; k++) press(4'b0001 << k, 12);
    check_scn("t6 lock");
    begin_scn();
    bus.mode = 1'b1;
    cycles(4);
    press(4'b0100, 12);
    check_scn("t6 locked display");
    bus.mode = 1'b0;
    cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
